// File: rtl/pixel_byte_cache.sv
// Direct-mapped, one-byte-per-line read cache in front of the 1-bpp image memory.
// Hits answer combinationally; a single outstanding fetch fills one line at a time.
module pixel_byte_cache #(
  parameter int LINES       = 8,
  parameter int ROW_BYTES   = 80,
  parameter int ROWS        = 480,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        pixel,
  output logic        ready,
  output logic [15:0] rdaddress,
  input  logic [7:0]  rdata,
  output logic [15:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 16 - IDX_W;
  localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [10:0] X_LIMIT = 11'(ROW_BYTES * 8);
  localparam logic [10:0] Y_LIMIT = 11'(ROWS);

  typedef enum logic [1:0] {IDLE, WAIT, FILL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               issue;
  logic               fill_we;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [7:0]         data_q [LINES];

  logic [17:0]        addr_full;
  logic [15:0]        req_addr;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               in_range;
  logic               hit;
  logic               miss;
  logic [7:0]         line_byte;

  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Lookup stage: address decode and tag compare against the registered array
  always_comb begin
    addr_full = 18'(y) * 18'(ROW_BYTES) + 18'(x[9:3]);
    req_addr  = addr_full[15:0];
    req_idx   = req_addr[IDX_W-1:0];
    req_tag   = req_addr[15:IDX_W];
    in_range  = ({1'b0, x} < X_LIMIT) && ({1'b0, y} < Y_LIMIT);
    line_byte = data_q[req_idx];
    hit       = in_range && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    miss      = in_range && !hit;
  end

  always_comb begin
    ready = 1'b0;
    pixel = 1'b0;
    if (reset_n) begin
      if (!in_range) begin
        ready = 1'b1;
      end else if (hit) begin
        ready = 1'b1;
        pixel = line_byte[x[2:0]];
      end
    end
  end

  // Fetch stage: the registered read address doubles as the latched index/tag
  assign fill_idx = rdaddress[IDX_W-1:0];
  assign fill_tag = rdaddress[15:IDX_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    fill_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          issue   = 1'b1;
          cnt_d   = CNT_W'(MEM_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = FILL;
      end
      FILL: begin
        fill_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      issue   = 1'b0;
      fill_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      rdaddress  <= '0;
      miss_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (flush) begin
        valid_q    <= '0;
        miss_count <= '0;
      end else begin
        if (fill_we) valid_q[fill_idx] <= 1'b1;
        if (issue) begin
          rdaddress  <= req_addr;
          miss_count <= sat_inc(miss_count);
        end
      end
    end
  end

  // Fill stage: line payload is never read without its valid bit, so it carries no reset
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[fill_idx] <= rdata;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_pixel_byte_cache.sv
// Bench for pixel_byte_cache: directed timing scenarios plus randomized requests
// scored against an image-memory / direct-mapped-cache reference model.
module tb_pixel_byte_cache;

  localparam int LINES       = 8;
  localparam int ROW_BYTES   = 80;
  localparam int ROWS        = 480;
  localparam int MEM_LATENCY = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        pixel, ready;
  logic [15:0] rdaddress, miss_count;
  logic [7:0]  rdata;

  logic [7:0]  mem [65536];
  logic [15:0] addr_r = '0;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic  pix;
    int    lat;
    int    mc;
    int    ra;
    string nm;
  } exp_t;

  exp_t sbq[$];
  bit   pending = 0;
  int   start_cyc = 0;

  // reference model state: which byte address each line currently holds
  int held[int];
  int model_miss = 0;
  int last_ra = 0;

  pixel_byte_cache #(
    .LINES(LINES), .ROW_BYTES(ROW_BYTES), .ROWS(ROWS), .MEM_LATENCY(MEM_LATENCY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .x(x), .y(y),
    .pixel(pixel), .ready(ready), .rdaddress(rdaddress), .rdata(rdata),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    addr_r <= rdaddress;
  end
  assign rdata = mem[addr_r];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic ref_pixel(input int xi, input int yi);
    logic [7:0] b;
    if (xi >= ROW_BYTES * 8 || yi >= ROWS) return 1'b0;
    b = mem[yi * ROW_BYTES + xi / 8];
    return b[xi % 8];
  endfunction

  function automatic void model_clear();
    held.delete();
    model_miss = 0;
  endfunction

  task automatic request(input int xi, input int yi, input string nm);
    exp_t e;
    int   a;
    bit   inr;
    bit   hit;
    inr = (xi < ROW_BYTES * 8) && (yi < ROWS);
    a   = (yi * ROW_BYTES + xi / 8) & 16'hFFFF;
    hit = held.exists(a % LINES) && (held[a % LINES] == a);
    e.pix = ref_pixel(xi, yi);
    e.lat = (!inr || hit) ? 0 : MEM_LATENCY + 2;
    if (inr && !hit) begin
      held[a % LINES] = a;
      if (model_miss < 65535) model_miss++;
      last_ra = a;
    end
    e.mc = model_miss;
    e.ra = last_ra;
    e.nm = nm;
    @(posedge clk); #1;
    x = 10'(xi);
    y = 10'(yi);
    start_cyc = cyc;
    sbq.push_back(e);
    pending = 1;
    for (int g = 0; g < 40 && pending; g++) @(posedge clk);
    if (pending) begin
      chk({nm, "_timeout"}, 32'(pending), 0);
      void'(sbq.pop_front());
      pending = 0;
    end
  endtask

  task automatic cyc_drive(input int xi, input int yi, input logic f);
    @(posedge clk); #1;
    x = 10'(xi);
    y = 10'(yi);
    flush = f;
    @(negedge clk);
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    x = 10'd640;
    y = 10'd0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  // monitor: scores every request the stimulus has outstanding once the DUT answers
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pending && ready && reset_n && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.nm, "_pixel"},   32'(pixel), 32'(e.pix));
        chk({e.nm, "_latency"}, cyc - start_cyc, e.lat);
        chk({e.nm, "_misses"},  32'(miss_count), e.mc);
        chk({e.nm, "_rdaddr"},  32'(rdaddress), e.ra);
        pending = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int xi, yi, r;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[160] = 8'h80;
    mem[240] = 8'h08;
    mem[248] = 8'h5A;
    mem[321] = 8'h02;
    mem[402] = 8'h04;

    // reset state, with an out-of-range request still forced to not-ready
    reset_n = 1'b0;
    x = 10'd640;
    y = 10'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_pixel", 32'(pixel), 0);
    chk("rst_rdaddr", 32'(rdaddress), 0);
    chk("rst_misses", 32'(miss_count), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // first fetch and same-line hits
    request(7, 2, "first_miss");
    request(0, 2, "same_line_bit0");
    request(7, 2, "same_line_bit7");

    // conflict eviction on line 0
    request(3, 3, "evict_a240");
    request(64, 3, "evict_a248");
    request(3, 3, "evict_a240_again");

    // out of range
    request(640, 0, "oor_x");
    request(0, 480, "oor_y");

    // hit under miss with a request change
    request(7, 2, "recache_160");
    cyc_drive(9, 4, 1'b0);
    chk("hum_c_ready", 32'(ready), 0);
    cyc_drive(7, 2, 1'b0);
    chk("hum_rdaddr_c1", 32'(rdaddress), 321);
    chk("hum_wait_hit_ready", 32'(ready), 1);
    chk("hum_wait_hit_pixel", 32'(pixel), 1);
    cyc_drive(9, 4, 1'b0);
    chk("hum_fill_ready", 32'(ready), 0);
    cyc_drive(9, 4, 1'b0);
    chk("hum_done_ready", 32'(ready), 1);
    chk("hum_done_pixel", 32'(pixel), 1);
    chk("hum_done_misses", 32'(miss_count), model_miss + 1);
    held[321 % LINES] = 321;
    model_miss++;
    last_ra = 321;
    request(9, 4, "hum_rehit");

    // flush while waiting on memory: nothing written, counter restarts
    cyc_drive(20, 5, 1'b0);
    chk("fw_c_ready", 32'(ready), 0);
    cyc_drive(20, 5, 1'b1);
    chk("fw_rdaddr", 32'(rdaddress), 402);
    cyc_drive(9, 4, 1'b0);
    chk("fw_after_ready", 32'(ready), 0);
    chk("fw_after_misses", 32'(miss_count), 0);
    cyc_drive(9, 4, 1'b0);
    chk("fw_refetch_misses", 32'(miss_count), 1);
    cyc_drive(9, 4, 1'b0);
    chk("fw_refetch_fill_ready", 32'(ready), 0);
    cyc_drive(9, 4, 1'b0);
    chk("fw_refetch_ready", 32'(ready), 1);
    chk("fw_refetch_pixel", 32'(pixel), 1);
    model_clear();
    held[321 % LINES] = 321;
    model_miss = 1;
    last_ra = 321;
    request(20, 5, "fw_not_written");

    // flush coinciding with the fill edge wins
    cyc_drive(20, 6, 1'b0);
    cyc_drive(20, 6, 1'b0);
    cyc_drive(20, 6, 1'b1);
    chk("ff_fill_ready", 32'(ready), 0);
    cyc_drive(20, 6, 1'b0);
    chk("ff_after_ready", 32'(ready), 0);
    chk("ff_after_misses", 32'(miss_count), 0);
    cyc_drive(20, 6, 1'b0);
    cyc_drive(20, 6, 1'b0);
    cyc_drive(20, 6, 1'b0);
    chk("ff_refetch_ready", 32'(ready), 1);
    chk("ff_refetch_pixel", 32'(pixel), 32'(ref_pixel(20, 6)));
    model_clear();
    held[482 % LINES] = 482;
    model_miss = 1;
    last_ra = 482;

    // image rewrite followed by flush must not serve the old byte
    request(7, 2, "pre_rewrite");
    mem[160] = 8'h00;
    do_flush();
    request(7, 2, "post_rewrite");

    // reset in the middle of a fetch
    cyc_drive(30, 7, 1'b0);
    cyc_drive(30, 7, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rmid_ready", 32'(ready), 0);
    x = 10'd640;
    #1;
    chk("rmid_oor_ready", 32'(ready), 0);
    repeat (2) @(negedge clk);
    chk("rmid_rdaddr", 32'(rdaddress), 0);
    chk("rmid_misses", 32'(miss_count), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_clear();
    last_ra = 0;
    request(640, 0, "rmid_oor_after");
    request(7, 2, "rmid_invalid_160");
    request(30, 7, "rmid_not_written");

    // randomized traffic with occasional image rewrite + flush
    for (int n = 0; n < 400; n++) begin
      if (n % 80 == 79) begin
        for (int k = 0; k < 4; k++) mem[$urandom_range(0, 38399)] = 8'($urandom);
        do_flush();
      end
      r = $urandom_range(0, 9);
      if (r == 0) begin
        xi = $urandom_range(640, 1023);
        yi = $urandom_range(0, 1023);
      end else if (r == 1) begin
        xi = $urandom_range(0, 1023);
        yi = $urandom_range(480, 1023);
      end else begin
        yi = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 5) : $urandom_range(474, 479);
        xi = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 127) : $urandom_range(560, 639);
      end
      request(xi, yi, "rnd");
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
